// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned N x N shift-and-add multiplier.
// One N-bit ripple-carry adder is shared across N iterations, with a three-state controller.
module seq_mult_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_m;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_q;
  logic          r_c;
  logic [CW-1:0] r_cnt;

  logic [N-1:0]  w_addend;
  logic [N-1:0]  w_sum;
  logic [N:0]    w_carry;

  assign w_addend   = r_q[0] ? r_m : '0;
  assign w_carry[0] = 1'b0;

  // Full-adder chain; w_carry[N] is the adder's carry-out and becomes C.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign w_sum[i]     = r_acc[i] ^ w_addend[i] ^ w_carry[i];
    assign w_carry[i+1] = (r_acc[i] & w_addend[i]) |
                          (r_acc[i] & w_carry[i])  |
                          (w_addend[i] & w_carry[i]);
  end

  // NOTE: every register here is state, so all assignments are non-blocking;
  // the async reset clears the datapath too, so no stale product survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= CW'(N);
            busy    <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          // Add then shift {C,ACC,Q} right: C into ACC MSB, ACC LSB into Q MSB.
          r_c   <= 1'b0;
          r_acc <= {w_carry[N], w_sum[N-1:1]};
          r_q   <= {w_sum[0], r_q[N-1:1]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            product <= {w_carry[N], w_sum, r_q[N-1:1]};
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // C is consumed by the shift in the same edge it is produced, so it rests at 0.
  a_c_clear : assert property (@(posedge clk) disable iff (rst) (r_c == 1'b0));

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: the stimulus pushes expected products and done cycles,
// and a negedge monitor pops them and compares whenever done is seen.
module tb_seq_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  seq_mult_ctrl #(.N(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] prod;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_product"}, {24'd0, product}, {24'd0, e.prod});
        check({e.name, "_latency"}, cyc, e.cyc);
        check({e.name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
      end
    end
  end

  // Called at a negedge; waits for idle, then issues a one-cycle start pulse.
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v,
                       input logic [7:0] exp_p, input string name);
    int waited = 0;
    while (busy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (busy) begin
      check({name, "_idle_wait"}, {31'd0, busy}, 32'd0);
    end else begin
      a     = ta;
      b     = tb_v;
      start = 1'b1;
      sb.push_back('{exp_p, cyc + 5, name});
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((busy || sb.size() != 0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    check("reset_busy",    {31'd0, busy},    32'd0);
    check("reset_done",    {31'd0, done},    32'd0);
    check("reset_product", {24'd0, product}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 5 x 6 with busy span: high for 5 cycles after the start edge, then low.
    do_op(4'd5, 4'd6, 8'h1E, "m5x6");
    for (int i = 0; i < 5; i++) begin
      check("busy_span", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check("busy_drop", {31'd0, busy}, 32'd0);

    do_op(4'd15, 4'd15, 8'hE1, "m15x15");
    do_op(4'd0,  4'd9,  8'h00, "m0x9");
    do_op(4'd9,  4'd7,  8'h3F, "m9x7");
    wait_idle();

    // Start while busy with new operands must be ignored.
    do_op(4'd3, 4'd4, 8'h0C, "ignore");
    @(negedge clk);
    a     = 4'd15;
    b     = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start held high: operations every 6 cycles.
    c     = cyc;
    a     = 4'd2;
    b     = 4'd3;
    start = 1'b1;
    sb.push_back('{8'h06, c + 5, "held1"});
    repeat (5) @(negedge clk);
    a = 4'd4;
    b = 4'd4;
    sb.push_back('{8'h10, c + 11, "held2"});
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset in the second CALC cycle aborts with no done.
    a     = 4'd7;
    b     = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",    {31'd0, busy},    32'd0);
    check("abort_done",    {31'd0, done},    32'd0);
    check("abort_product", {24'd0, product}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(4'd1, 4'd1, 8'h01, "post_reset");
    wait_idle();

    // Exhaustive sweep; latency is checked per operation by the monitor.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        do_op(4'(ia), 4'(ib), 8'(ia * ib), "sweep");
      end
    end

    begin
      int w = 0;
      while (sb.size() != 0 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (sb.size() != 0) check("drain", sb.size(), 32'd0);
    end
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
